// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame width and default bit period.
// Intended for reuse by uart_rx_core and the future uart_tx_core.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200 baud

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high input pin.
// Both flops reset to 1 so that leaving reset never looks like a falling edge.
module uart_sync2 (
    input  logic clock,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic sync1_d, sync1_q;
    logic sync2_d, sync2_q;

    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
    end

    // NOTE: non-blocking assignments let both flops sample their old values on the same edge.
    always_ff @(posedge clock) begin
        if (resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign q = sync2_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronizes RXD, samples mid-bit, pulses RX_dv per good byte.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 uart_RXD,
    output logic [DATA_BITS-1:0] RX_data,
    output logic                 RX_dv,
    output logic                 framing_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int                CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]     CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0]     CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST = 3'(DATA_BITS - 1);

    logic rx_s;

    uart_sync2 u_sync (
        .clock  (clock),
        .resetn (resetn),
        .d      (uart_RXD),
        .q      (rx_s)
    );

    uart_state_e          state_d, state_q;
    logic [CW-1:0]        cnt_d, cnt_q;
    logic [2:0]           bit_d, bit_q;
    logic [DATA_BITS-1:0] shift_d, shift_q;
    logic [DATA_BITS-1:0] data_d, data_q;
    logic                 dv_d, dv_q;
    logic                 fe_d, fe_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_d, par_q;
    logic                 pe_d, pe_q;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        pe_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shift_q, par_q}) begin
                            pe_d = 1'b1;
                        end else begin
                            data_d = shift_q;
                            dv_d   = 1'b1;
                        end
`else
                        data_d = shift_q;
                        dv_d   = 1'b1;
`endif
                    end else begin
                        // Line still low at the stop bit: wait for it to idle again.
                        fe_d    = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            pe_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            pe_q    <= pe_d;
`endif
        end
    end

    assign RX_data     = data_q;
    assign RX_dv       = dv_q;
    assign framing_err = fe_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = pe_q;
`else
    assign parity_err  = 1'b0;
`endif
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core at 16 clocks per bit; frames are queued when driven
// and matched (kind, byte, exact cycle) when RX_dv / framing_err / parity_err pulse.
module tb_uart_rx_core;

    localparam int N    = 16;
    localparam int HALF = (N - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_OFS = HALF + 10 * N;
`else
    localparam int STOP_OFS = HALF + 9 * N;
`endif

    typedef enum int { EV_DV, EV_FE, EV_PE } ev_e;
    typedef struct {
        ev_e        kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clock;
    logic       resetn;
    logic       uart_RXD;
    logic [7:0] RX_data;
    logic       RX_dv;
    logic       framing_err;
    logic       parity_err;
    logic       busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    exp_t       sb_q[$];
    logic [7:0] model_data = 8'h00;

    uart_rx_core #(.CLKS_PER_BIT(N)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .uart_RXD    (uart_RXD),
        .RX_data     (RX_data),
        .RX_dv       (RX_dv),
        .framing_err (framing_err),
        .parity_err  (parity_err),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: each pulse must match the oldest outstanding frame.
    always @(negedge clock) begin
        if (!resetn && (RX_dv || framing_err || parity_err)) begin
            exp_t e;
            ev_e  got_kind;
            got_kind = RX_dv ? EV_DV : (framing_err ? EV_FE : EV_PE);
            check("pulse_exclusive", 32'(RX_dv) + 32'(framing_err) + 32'(parity_err), 1);
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", 32'(got_kind), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("pulse_kind", 32'(got_kind), 32'(e.kind));
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                if (e.kind == EV_DV) model_data = e.data;
                check("rx_data", 32'(RX_data), 32'(model_data));
            end
        end
    end

    // Called at a negedge; drives a whole frame and returns at the negedge after the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        exp_t e;
        e.data = b;
        e.cyc  = cyc + 3 + STOP_OFS + 1;  // 2 sync flops + IDLE decision, then the pulse cycle
        if (!stop_bit)     e.kind = EV_FE;
        else if (par_flip) e.kind = EV_PE;
        else               e.kind = EV_DV;
        sb_q.push_back(e);
        uart_RXD = 1'b0;
        repeat (N) @(negedge clock);
        for (int k = 0; k < 8; k++) begin
            uart_RXD = b[k];
            repeat (N) @(negedge clock);
        end
`ifdef UART_RX_PARITY_EN
        uart_RXD = (^b) ^ par_flip;
        repeat (N) @(negedge clock);
`endif
        uart_RXD = stop_bit;
        repeat (N) @(negedge clock);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 4000 && sb_q.size() != 0; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        check(tag, 32'(sb_q.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b1;
        uart_RXD = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_rx_data", 32'(RX_data), 0);
        check("reset_rx_dv", 32'(RX_dv), 0);
        check("reset_framing_err", 32'(framing_err), 0);
        check("reset_parity_err", 32'(parity_err), 0);
        check("reset_busy", 32'(busy), 0);
        resetn = 1'b0;
        repeat (4) @(negedge clock);

        // Nominal frame
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (4) @(negedge clock);
        wait_drain("drain_nominal");
        check("idle_after_nominal", 32'(busy), 0);

        // Glitch shorter than half a bit
        uart_RXD = 1'b0;
        repeat (4) @(negedge clock);
        uart_RXD = 1'b1;
        repeat (3) @(negedge clock);
        check("glitch_busy_mid", 32'(busy), 1);
        repeat (20) @(negedge clock);
        check("glitch_idle", 32'(busy), 0);
        check("glitch_hold", 32'(RX_data), 32'(model_data));

        // Framing error with line held low for 40 cycles from the stop bit
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (12) @(negedge clock);
        check("break_busy", 32'(busy), 1);
        repeat (12) @(negedge clock);
        check("break_busy_late", 32'(busy), 1);
        uart_RXD = 1'b1;
        repeat (5) @(negedge clock);
        check("break_released", 32'(busy), 0);
        check("framing_hold", 32'(RX_data), 32'h0000_00A5);
        wait_drain("drain_framing");

        // Back-to-back frames, zero idle gap
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        uart_RXD = 1'b1;
        wait_drain("drain_b2b");

        // Reset during data bit 4 of 0x81, then a clean 0x42
        uart_RXD = 1'b0;
        repeat (N) @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            uart_RXD = k[0] ? 1'b0 : (k == 0);
            repeat ((k == 4) ? N / 2 : N) @(negedge clock);
        end
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        uart_RXD   = 1'b1;
        resetn     = 1'b0;
        model_data = 8'h00;
        check("midreset_rx_data", 32'(RX_data), 0);
        check("midreset_busy", 32'(busy), 0);
        repeat (N) @(negedge clock);
        check("midreset_no_pulse", 32'(busy), 0);
        send_frame(8'h42, 1'b1, 1'b0);
        uart_RXD = 1'b1;
        wait_drain("drain_after_reset");
        check("after_reset_data", 32'(RX_data), 32'h0000_0042);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        uart_RXD = 1'b1;
        wait_drain("drain_parity");
        check("parity_hold", 32'(RX_data), 32'h0000_0007);
`endif

        repeat (N) @(negedge clock);
        check("final_idle", 32'(busy), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial receive stage of the UART IP; sits directly downstream of the RXD pin and upstream of the Avalon UART interface.
- Synchronizes the asynchronous RXD line and detects the start bit.
- Samples 8N1 frames at mid-bit and delivers each byte with a single-cycle valid strobe. The Avalon side latches the strobe into its rx_valid flag.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range >= 4.
- DATA_BITS, 8, data bits per frame; fixed at 8, no other value supported.

Ports:
- clock  input  1  system clock, single clock domain.
- resetn  input  1  synchronous, active-high reset, despite the name.
- uart_RXD  input  1  asynchronous serial input; idle level 1.
- RX_data  output  8  last correctly received byte.
- RX_dv  output  1  one-cycle pulse: RX_data has just been updated.
- framing_err  output  1  one-cycle pulse: stop bit sampled as 0.
- parity_err  output  1  one-cycle pulse: parity mismatch (see Optional Feature).
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: RX_data=0x00, RX_dv=0, framing_err=0, parity_err=0, busy=0, FSM=IDLE, bit counter=0, clock counter=0, both synchronizer flops=1.
- Reset has priority over every other event. Reset mid-frame discards the partial byte and produces no pulse.
- Synchronizer: two flops on uart_RXD. rx_s is the second flop's output. All decisions use rx_s.
- Clock counter: width $clog2(CLKS_PER_BIT). Clears on every state transition.
- IDLE: rx_s==0 -> START. Call this cycle t0.
- START: wait until counter==(CLKS_PER_BIT-1)/2 (integer division), then sample.
  - rx_s==0 -> DATA.
  - rx_s==1 -> glitch; return to IDLE with no output pulse.
- DATA: sample at counter==CLKS_PER_BIT-1.
  - Shift into a shift register, LSB first.
  - Bit index 0..7; after bit 7 -> STOP (or PARITY when the feature is enabled).
- STOP: sample at counter==CLKS_PER_BIT-1.
  - rx_s==1 -> load RX_data from the shift register; RX_dv=1 for the next cycle only; -> IDLE.
  - rx_s==0 -> framing_err=1 for one cycle; RX_data unchanged; -> BREAK.
- BREAK: stay until rx_s==1, then -> IDLE. A held-low line never creates phantom frames.
- Timing, with N=CLKS_PER_BIT:
  - Start sample at t0+(N-1)/2.
  - Data bit k sampled at t0+(N-1)/2+(k+1)·N.
  - Stop sample at t0+(N-1)/2+9N.
  - RX_dv high in the following cycle.
- Back-to-back frames: IDLE is re-entered on the cycle after the stop sample. A start edge arriving during the second half of the stop bit is detected normally.
- RX_dv, framing_err and parity_err are mutually exclusive in any cycle.
- RX_data holds its value between frames; it changes only on the RX_dv cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted after DATA; it samples at counter==CLKS_PER_BIT-1, then goes to STOP.
  - Parity is even: XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch: parity_err pulses for one cycle coincident with the stop-sample decision; RX_dv is suppressed and RX_data is unchanged.
  - A framing error takes precedence: only framing_err pulses.
  - Frame timing becomes t0+(N-1)/2+10N for the stop sample.
- Undefined: no PARITY state; parity_err tied to 0.

Decomposition:
- Shared uart package/include holds:
  - state encodings IDLE, START, DATA, PARITY, STOP, BREAK;
  - DATA_BITS=8;
  - the default CLKS_PER_BIT.
- The future uart_tx_core reuses the same package.
- One sub-module: uart_sync2, a two-flop synchronizer with reset value 1, reusable for other asynchronous pins.

Test Plan:
- Nominal frame, N=16: send 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop=1) -> RX_data=0xA5. RX_dv high exactly one cycle at t0+7+144+1 relative to rx_s falling. framing_err=0.
- Glitch, N=16: RXD low for 4 cycles, then high -> FSM returns to IDLE. No RX_dv or framing_err. RX_data keeps its previous value.
- Framing error: 0x3C with stop=0, line held low 40 cycles, then high -> single framing_err pulse. No RX_dv. busy stays high until the line returns high. RX_data unchanged.
- Back-to-back: 0x00 then 0xFF with zero idle gap -> two RX_dv pulses, exactly 10N cycles apart, carrying 0x00 then 0xFF.
- Reset mid-frame: assert resetn during data bit 4 of 0x81, release, then send 0x42 -> no pulse for the aborted frame. Next RX_dv carries 0x42.
- Parity (UART_RX_PARITY_EN): 0x07 with parity bit 1 -> RX_dv, 0x07. 0x07 with parity bit 0 -> parity_err pulse, no RX_dv.
